// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one cache-line reader among NREQ requesters.
// One line read in flight; the returned line is routed back to the granted port.
module mem_read_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_cyc,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_cancel,
  output logic [NREQ-1:0]        resp_cyc,
  output logic [LINE_W-1:0]      resp_data,
  output logic                   rd_reqcyc,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_respcyc,
  input  logic [LINE_W-1:0]      rd_data,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic             drop;

  logic [NREQ-1:0]  eligible;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;

  assign eligible = req_cyc & ~req_cancel;

  // First eligible port at or after rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!pick_found && eligible[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign rr_next = (grant == IDX_W'(NREQ-1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      rd_addr   <= '0;
      resp_data <= '0;
      drop      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant   <= pick_idx;
            rd_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_cancel[grant]) begin
            drop <= 1'b1;
          end
          state <= ST_WAIT;
        end
        // The reader cannot be aborted, so a cancel only suppresses the response.
        ST_WAIT: begin
          if (req_cancel[grant]) begin
            drop <= 1'b1;
          end
          if (rd_respcyc) begin
            resp_data <= rd_data;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          drop   <= 1'b0;
          rr_ptr <= rr_next;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    resp_cyc = '0;
    if (state == ST_DONE && !drop) begin
      resp_cyc[grant] = 1'b1;
    end
  end

  assign rd_reqcyc = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

  // A reader completion outside WAIT is a protocol violation; the FSM ignores it.
  assert property (@(posedge clk) disable iff (reset) rd_respcyc |-> (state == ST_WAIT));

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Table-driven bench for mem_read_arbiter plus hand-written sequences for
// reset during WAIT and back-to-back re-request latency.
module tb_mem_read_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 512;
  localparam logic [ADDR_W-1:0] ADDR1 = 64'h2000;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_cyc;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_cancel;
  logic [NREQ-1:0]        resp_cyc;
  logic [LINE_W-1:0]      resp_data;
  logic                   rd_reqcyc;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_respcyc;
  logic [LINE_W-1:0]      rd_data;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_cyc    (req_cyc),
    .req_addr   (req_addr),
    .req_cancel (req_cancel),
    .resp_cyc   (resp_cyc),
    .resp_data  (resp_data),
    .rd_reqcyc  (rd_reqcyc),
    .rd_addr    (rd_addr),
    .rd_respcyc (rd_respcyc),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  // One row = inputs held across one rising edge, and outputs expected just after it.
  typedef struct {
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        can;
    logic [ADDR_W-1:0] a0;
    logic              rsp;
    logic [7:0]        tag;
    logic              exp_rq;
    logic [ADDR_W-1:0] exp_addr;
    logic [1:0]        exp_resp;
    logic              exp_busy;
    logic              chk_data;
    logic [7:0]        exp_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [LINE_W-1:0] mkLine(input logic [7:0] tag);
    return {64{tag}};
  endfunction

  function automatic vec_t mkVec(input logic rst, input logic [1:0] req, input logic [1:0] can,
                                 input logic [ADDR_W-1:0] a0, input logic rsp, input logic [7:0] tag,
                                 input logic exp_rq, input logic [ADDR_W-1:0] exp_addr,
                                 input logic [1:0] exp_resp, input logic exp_busy,
                                 input logic chk_data, input logic [7:0] exp_tag);
    vec_t v;
    v.rst = rst; v.req = req; v.can = can; v.a0 = a0; v.rsp = rsp; v.tag = tag;
    v.exp_rq = exp_rq; v.exp_addr = exp_addr; v.exp_resp = exp_resp;
    v.exp_busy = exp_busy; v.chk_data = chk_data; v.exp_tag = exp_tag;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] req, input logic [1:0] can,
                               input logic [ADDR_W-1:0] a0, input logic rsp, input logic [7:0] tag);
    @(negedge clk);
    reset      = rst;
    req_cyc    = req;
    req_cancel = can;
    req_addr   = {ADDR1, a0};
    rd_respcyc = rsp;
    rd_data    = mkLine(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tagname, input logic exp_rq, input logic [ADDR_W-1:0] exp_addr,
                          input logic [1:0] exp_resp, input logic exp_busy);
    checkOutput({tagname, " rd_reqcyc"}, LINE_W'(rd_reqcyc), LINE_W'(exp_rq));
    checkOutput({tagname, " rd_addr"},   LINE_W'(rd_addr),   LINE_W'(exp_addr));
    checkOutput({tagname, " resp_cyc"},  LINE_W'(resp_cyc),  LINE_W'(exp_resp));
    checkOutput({tagname, " busy"},      LINE_W'(busy),      LINE_W'(exp_busy));
  endtask

  initial begin
    int   wait_n;
    logic seen;

    reset      = 1'b1;
    req_cyc    = '0;
    req_cancel = '0;
    req_addr   = '0;
    rd_respcyc = 1'b0;
    rd_data    = '0;

    //                rst req    can    a0        rsp tag    rq addr      resp   bsy chk etag
    vecs.push_back(mkVec(1, 2'b00, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h0000, 2'b00, 0, 1, 8'h00));
    // single request from port 0
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 1, 8'h11, 0, 64'h1000, 2'b01, 1, 1, 8'h11));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 0, 0, 8'h00));
    // contention: port0, port1, then port0 again
    vecs.push_back(mkVec(1, 2'b00, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h0000, 2'b00, 0, 1, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 1, 8'h22, 0, 64'h1000, 2'b01, 1, 1, 8'h22));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 0, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 1, 8'h33, 0, 64'h2000, 2'b10, 1, 1, 8'h33));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h2000, 2'b00, 0, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 1, 8'h44, 0, 64'h1000, 2'b01, 1, 1, 8'h44));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 0, 0, 8'h00));
    // port1 cancels in WAIT: response dropped, pointer still advances to port0
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b10, 2'b10, 64'h1000, 0, 8'h00, 0, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 1, 8'h55, 0, 64'h2000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h2000, 2'b00, 0, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1000, 0, 8'h00, 1, 64'h1000, 2'b00, 1, 0, 8'h00));
    // address change after grant is ignored
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1234, 0, 8'h00, 0, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b11, 2'b00, 64'h1234, 1, 8'h66, 0, 64'h1000, 2'b01, 1, 1, 8'h66));
    vecs.push_back(mkVec(0, 2'b10, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 0, 0, 8'h00));
    // port1 has priority but is masked by its cancel, so port0 wins
    vecs.push_back(mkVec(0, 2'b11, 2'b10, 64'h1000, 0, 8'h00, 1, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 1, 0, 8'h00));
    vecs.push_back(mkVec(0, 2'b01, 2'b00, 64'h1000, 1, 8'h77, 0, 64'h1000, 2'b01, 1, 1, 8'h77));
    vecs.push_back(mkVec(0, 2'b00, 2'b00, 64'h1000, 0, 8'h00, 0, 64'h1000, 2'b00, 0, 0, 8'h00));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].can, vecs[i].a0, vecs[i].rsp, vecs[i].tag);
      checkAll($sformatf("row%0d", i), vecs[i].exp_rq, vecs[i].exp_addr, vecs[i].exp_resp, vecs[i].exp_busy);
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("row%0d resp_data", i), resp_data, mkLine(vecs[i].exp_tag));
      end
    end

    // Reset while WAIT: everything returns to zero, and a late reader pulse has no effect.
    applyStimulus(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00);
    checkAll("rst_mid issue", 1'b1, 64'h1000, 2'b00, 1'b1);
    applyStimulus(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00);
    checkAll("rst_mid wait", 1'b0, 64'h1000, 2'b00, 1'b1);
    applyStimulus(1, 2'b00, 2'b00, 64'h1000, 0, 8'h00);
    checkAll("rst_mid reset", 1'b0, 64'h0, 2'b00, 1'b0);
    checkOutput("rst_mid resp_data", resp_data, '0);
    applyStimulus(1, 2'b00, 2'b00, 64'h1000, 1, 8'h99);
    checkAll("rst_mid late_rsp", 1'b0, 64'h0, 2'b00, 1'b0);
    checkOutput("rst_mid late_rsp data", resp_data, '0);
    applyStimulus(0, 2'b00, 2'b00, 64'h1000, 0, 8'h00);
    checkAll("rst_mid after", 1'b0, 64'h0, 2'b00, 1'b0);

    // Back-to-back: port0 keeps req_cyc high through DONE.
    applyStimulus(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00);
    checkAll("b2b issue", 1'b1, 64'h1000, 2'b00, 1'b1);
    applyStimulus(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00);
    applyStimulus(0, 2'b01, 2'b00, 64'h1000, 1, 8'h88);
    checkAll("b2b done", 1'b0, 64'h1000, 2'b01, 1'b1);
    checkOutput("b2b resp_data", resp_data, mkLine(8'h88));
    seen   = 1'b0;
    wait_n = 0;
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(0, 2'b01, 2'b00, 64'h1000, 0, 8'h00);
      if (rd_reqcyc) begin
        seen   = 1'b1;
        wait_n = n;
        break;
      end
    end
    checkOutput("b2b reissue seen", LINE_W'(seen), LINE_W'(1'b1));
    if (seen) begin
      checkOutput("b2b cycles after rd_respcyc", LINE_W'(wait_n + 1), LINE_W'(3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
